// File: rtl/datapath_hs.sv
// rtl/datapath_hs.sv - handshaked datapath: register file, ALU, status, PC, req/ack data memory
module datapath_hs #(
    parameter int DATA_W   = 64,
    parameter int PC_W     = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = NREGS - 1,
    localparam int RA_W    = $clog2(NREGS)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_op_valid,
    output logic              o_op_ready,
    input  logic [RA_W-1:0]   i_reg_addr,
    input  logic [RA_W-1:0]   i_a_addr,
    input  logic [RA_W-1:0]   i_b_addr,
    input  logic [DATA_W-1:0] i_k,
    input  logic [2:0]        i_fs,
    input  logic              i_b_sel,
    input  logic              i_c0,
    input  logic [1:0]        i_dst_sel,
    input  logic              i_reg_w,
    input  logic              i_stat_en,
    input  logic [1:0]        i_mem_op,
    input  logic [1:0]        i_ps,
    input  logic              i_pc_sel,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [PC_W-1:0]   o_rom_addr,
    output logic [4:0]        o_status
);
    localparam int SH_W = $clog2(DATA_W);
    localparam int MSB  = DATA_W - 1;
    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_MEM_WAIT = 1'b1;

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [PC_W-1:0]   r_pc;
    logic [3:0]        r_status;
    logic [0:0]        r_state;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_l_wb;
    logic [RA_W-1:0]   r_l_reg_addr;
    logic              r_l_reg_w;
    logic [1:0]        r_l_dst_sel;
    logic [PC_W-1:0]   r_l_pc_next;

    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b_port;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_f;
    logic              w_c;
    logic              w_v;
    logic              w_z;
    logic              w_n;
    logic              w_accept;
    logic              w_is_mem;
    logic [PC_W-1:0]   w_pc_plus4;
    logic [PC_W-1:0]   w_pc_next;
    logic [DATA_W-1:0] w_link;
    logic [DATA_W-1:0] w_wb_now;
    logic              w_we;
    logic [RA_W-1:0]   w_wa;
    logic [DATA_W-1:0] w_wd;

    assign w_a      = (i_a_addr == RA_W'(ZERO_REG)) ? '0 : r_regs[i_a_addr];
    assign w_b_port = (i_b_addr == RA_W'(ZERO_REG)) ? '0 : r_regs[i_b_addr];
    assign w_b      = i_b_sel ? i_k : w_b_port;

    // ALU: carry and overflow are only meaningful for ADD/SUB, zero otherwise
    always_comb begin
        w_sum = '0;
        w_f   = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (i_fs)
            3'b000: w_f = w_a & w_b;
            3'b001: w_f = w_a | w_b;
            3'b010: begin
                w_sum = {1'b0, w_a} + {1'b0, w_b} + {{DATA_W{1'b0}}, i_c0};
                w_f   = w_sum[DATA_W-1:0];
                w_c   = w_sum[DATA_W];
                w_v   = (w_a[MSB] == w_b[MSB]) && (w_f[MSB] != w_a[MSB]);
            end
            3'b011: begin
                w_sum = {1'b0, w_a} + {1'b0, ~w_b} + {{DATA_W{1'b0}}, 1'b1};
                w_f   = w_sum[DATA_W-1:0];
                w_c   = w_sum[DATA_W];
                w_v   = (w_a[MSB] != w_b[MSB]) && (w_f[MSB] != w_a[MSB]);
            end
            3'b100:  w_f = w_a ^ w_b;
            3'b101:  w_f = w_a << w_b[SH_W-1:0];
            3'b110:  w_f = w_a >> w_b[SH_W-1:0];
            default: w_f = w_b;
        endcase
    end

    assign w_z        = (w_f == '0);
    assign w_n        = w_f[MSB];
    assign w_is_mem   = (i_mem_op == 2'b01) || (i_mem_op == 2'b10);
    assign w_accept   = i_op_valid && (r_state == S_IDLE);
    assign w_pc_plus4 = r_pc + PC_W'(4);
    assign w_link     = DATA_W'(w_pc_plus4);

    // next PC from the PC at acceptance; all arithmetic wraps at PC_W bits
    always_comb begin
        w_pc_next = r_pc;
        case (i_ps)
            2'b01:   w_pc_next = w_pc_plus4;
            2'b10:   w_pc_next = i_pc_sel ? i_k[PC_W-1:0] : w_a[PC_W-1:0];
            2'b11:   w_pc_next = r_pc + (i_k[PC_W-1:0] << 2);
            default: w_pc_next = r_pc;
        endcase
    end

    // write-back source selection for the op being accepted
    always_comb begin
        w_wb_now = w_f;
        case (i_dst_sel)
            2'b01:   w_wb_now = w_b_port;
            2'b10:   w_wb_now = i_mem_rdata;
            2'b11:   w_wb_now = w_link;
            default: w_wb_now = w_f;
        endcase
    end

    // single register write port: immediate ops in IDLE, memory completion in MEM_WAIT
    always_comb begin
        w_we = 1'b0;
        w_wa = i_reg_addr;
        w_wd = w_wb_now;
        if (r_state == S_IDLE) begin
            w_we = w_accept && !w_is_mem && i_reg_w;
        end else if (i_mem_ack && r_l_reg_w) begin
            w_we = 1'b1;
            w_wa = r_l_reg_addr;
            w_wd = (r_l_dst_sel == 2'b10) ? i_mem_rdata : r_l_wb;
        end
        if (w_wa == RA_W'(ZERO_REG)) begin
            w_we = 1'b0;
        end
    end

    // register file storage; reads above see the old value during a write
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[w_wa] <= w_wd;
        end
    end

    // control FSM, PC, status and the registered memory request
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_pc         <= '0;
            r_status     <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_l_wb       <= '0;
            r_l_reg_addr <= '0;
            r_l_reg_w    <= 1'b0;
            r_l_dst_sel  <= '0;
            r_l_pc_next  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (i_stat_en) begin
                            r_status <= {w_v, w_c, w_n, w_z};
                        end
                        if (w_is_mem) begin
                            r_mem_addr   <= w_f;
                            r_mem_wdata  <= w_b_port;
                            r_mem_we     <= (i_mem_op == 2'b10);
                            r_mem_req    <= 1'b1;
                            r_l_wb       <= w_wb_now;
                            r_l_reg_addr <= i_reg_addr;
                            r_l_reg_w    <= i_reg_w;
                            r_l_dst_sel  <= i_dst_sel;
                            r_l_pc_next  <= w_pc_next;
                            r_state      <= S_MEM_WAIT;
                        end else begin
                            r_pc <= w_pc_next;
                        end
                    end
                end
                S_MEM_WAIT: begin
                    if (i_mem_ack) begin
                        r_pc      <= r_l_pc_next;
                        r_mem_req <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_op_ready  = (r_state == S_IDLE);
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_rom_addr  = r_pc;
    assign o_status    = {r_status, w_z};
endmodule

// File: tb/tb_datapath_hs.sv
// tb/tb_datapath_hs.sv - directed self-checking bench for datapath_hs
module tb_datapath_hs;
    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic        op_ready;
    logic [4:0]  reg_addr;
    logic [4:0]  a_addr;
    logic [4:0]  b_addr;
    logic [63:0] k;
    logic [2:0]  fs;
    logic        b_sel;
    logic        c0;
    logic [1:0]  dst_sel;
    logic        reg_w;
    logic        stat_en;
    logic [1:0]  mem_op;
    logic [1:0]  ps;
    logic        pc_sel;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic [31:0] rom_addr;
    logic [4:0]  status;

    int checks = 0;
    int errors = 0;
    logic [63:0] av;
    logic [63:0] bv;

    datapath_hs dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_op_valid(op_valid), .o_op_ready(op_ready),
        .i_reg_addr(reg_addr), .i_a_addr(a_addr), .i_b_addr(b_addr), .i_k(k),
        .i_fs(fs), .i_b_sel(b_sel), .i_c0(c0), .i_dst_sel(dst_sel), .i_reg_w(reg_w),
        .i_stat_en(stat_en), .i_mem_op(mem_op), .i_ps(ps), .i_pc_sel(pc_sel),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
        .o_rom_addr(rom_addr), .o_status(status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        op_valid = 1'b0; reg_addr = 5'd0; a_addr = 5'd0; b_addr = 5'd0; k = 64'd0;
        fs = 3'b000; b_sel = 1'b0; c0 = 1'b0; dst_sel = 2'b00; reg_w = 1'b0;
        stat_en = 1'b0; mem_op = 2'b00; ps = 2'b00; pc_sel = 1'b0;
        mem_ack = 1'b0; mem_rdata = 64'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // r[rd] = r0 + value (r0 stays zero throughout)
    task automatic wr_k(input logic [4:0] rd, input logic [63:0] value);
        clr();
        op_valid = 1'b1; fs = 3'b010; b_sel = 1'b1; k = value; reg_addr = rd; reg_w = 1'b1;
        step();
        clr();
    endtask

    // store of A|0 with B as data exposes A on mem_addr and B on mem_wdata
    task automatic read_regs(input logic [4:0] ra, input logic [4:0] rb,
                             output logic [63:0] a_val, output logic [63:0] b_val);
        clr();
        op_valid = 1'b1; mem_op = 2'b10; fs = 3'b001; b_sel = 1'b1; k = 64'd0;
        a_addr = ra; b_addr = rb;
        step();
        op_valid = 1'b0;
        a_val = mem_addr;
        b_val = mem_wdata;
        mem_ack = 1'b1;
        step();
        clr();
    endtask

    initial begin
        clr();
        rst_n = 1'b0;
        #12;
        chk("reset_rom_addr", 64'(rom_addr), 64'h0);
        chk("reset_status", 64'(status[4:1]), 64'h0);
        chk("reset_mem_req", 64'(mem_req), 64'h0);
        chk("reset_mem_we", 64'(mem_we), 64'h0);
        rst_n = 1'b1;
        #1;
        chk("reset_op_ready", 64'(op_ready), 64'h1);
        step();

        wr_k(5'd1, 64'd5);
        chk("prep_pc_hold", 64'(rom_addr), 64'h0);
        op_valid = 1'b1; fs = 3'b010; a_addr = 5'd1; b_sel = 1'b1; k = 64'd7;
        reg_addr = 5'd2; reg_w = 1'b1; stat_en = 1'b1; ps = 2'b01;
        step();
        clr();
        chk("add_rom_addr", 64'(rom_addr), 64'h4);
        chk("add_status", 64'(status[4:1]), 64'h0);
        read_regs(5'd2, 5'd1, av, bv);
        chk("add_r2", av, 64'd12);
        chk("add_r1", bv, 64'd5);

        wr_k(5'd5, 64'd3);
        op_valid = 1'b1; fs = 3'b011; a_addr = 5'd5; b_sel = 1'b1; k = 64'd3; stat_en = 1'b1;
        step();
        clr();
        chk("sub_status_zc", 64'(status[4:1]), 64'b0101);

        wr_k(5'd6, 64'h7FFF_FFFF_FFFF_FFFF);
        op_valid = 1'b1; fs = 3'b010; a_addr = 5'd6; b_sel = 1'b1; k = 64'd1; stat_en = 1'b1;
        step();
        clr();
        chk("add_ovf_status_vn", 64'(status[4:1]), 64'b1010);

        clr();
        op_valid = 1'b1; fs = 3'b010; b_sel = 1'b1; k = 64'd1; c0 = 1'b1;
        reg_addr = 5'd7; reg_w = 1'b1;
        step();
        clr();
        read_regs(5'd7, 5'd0, av, bv);
        chk("add_carry_in", av, 64'd2);

        wr_k(5'd3, 64'hDEAD);
        op_valid = 1'b1; mem_op = 2'b10; fs = 3'b010; a_addr = 5'd0; b_sel = 1'b1;
        k = 64'h10; b_addr = 5'd3;
        step();
        op_valid = 1'b0;
        chk("st_mem_req", 64'(mem_req), 64'h1);
        chk("st_mem_we", 64'(mem_we), 64'h1);
        chk("st_op_ready", 64'(op_ready), 64'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_wait_req", 64'(mem_req), 64'h1);
            chk("st_wait_addr", mem_addr, 64'h10);
            chk("st_wait_wdata", mem_wdata, 64'hDEAD);
            chk("st_wait_ready", 64'(op_ready), 64'h0);
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("st_done_req", 64'(mem_req), 64'h0);
        chk("st_done_ready", 64'(op_ready), 64'h1);

        clr();
        op_valid = 1'b1; mem_op = 2'b01; fs = 3'b010; b_sel = 1'b1; k = 64'h10;
        reg_addr = 5'd4; reg_w = 1'b1; dst_sel = 2'b10;
        step();
        op_valid = 1'b0;
        chk("ld_mem_we", 64'(mem_we), 64'h0);
        chk("ld_mem_addr", mem_addr, 64'h10);
        mem_ack = 1'b1; mem_rdata = 64'hDEAD;
        step();
        clr();
        read_regs(5'd4, 5'd0, av, bv);
        chk("ld_r4", av, 64'hDEAD);

        wr_k(5'd31, 64'h55);
        read_regs(5'd31, 5'd31, av, bv);
        chk("zero_reg_a", av, 64'h0);
        chk("zero_reg_b", bv, 64'h0);

        clr();
        op_valid = 1'b1; ps = 2'b10; pc_sel = 1'b1; k = 64'h20;
        step();
        chk("pc_load_k_20", 64'(rom_addr), 64'h20);
        ps = 2'b11; pc_sel = 1'b0; k = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        chk("pc_offset_neg", 64'(rom_addr), 64'h18);
        ps = 2'b10; pc_sel = 1'b1; k = 64'h100;
        step();
        chk("pc_load_k_100", 64'(rom_addr), 64'h100);
        ps = 2'b10; pc_sel = 1'b0; a_addr = 5'd2;
        step();
        chk("pc_load_a", 64'(rom_addr), 64'hC);
        ps = 2'b10; pc_sel = 1'b1; k = 64'h40;
        step();
        clr();

        op_valid = 1'b1; dst_sel = 2'b11; reg_addr = 5'd8; reg_w = 1'b1; ps = 2'b01;
        step();
        clr();
        chk("link_pc", 64'(rom_addr), 64'h44);
        read_regs(5'd8, 5'd0, av, bv);
        chk("link_r8", av, 64'h44);

        op_valid = 1'b1; a_addr = 5'd2; b_sel = 1'b1; reg_w = 1'b1; ps = 2'b01;
        fs = 3'b100; k = 64'hF; reg_addr = 5'd9;
        step();
        chk("b2b_ready_1", 64'(op_ready), 64'h1);
        fs = 3'b001; k = 64'h30; reg_addr = 5'd10;
        step();
        chk("b2b_ready_2", 64'(op_ready), 64'h1);
        fs = 3'b101; k = 64'h44; reg_addr = 5'd11;
        step();
        chk("b2b_ready_3", 64'(op_ready), 64'h1);
        fs = 3'b110; k = 64'h2; reg_addr = 5'd12;
        step();
        clr();
        chk("b2b_pc", 64'(rom_addr), 64'h54);
        read_regs(5'd9, 5'd10, av, bv);
        chk("b2b_xor", av, 64'h3);
        chk("b2b_or", bv, 64'h3C);
        read_regs(5'd11, 5'd12, av, bv);
        chk("b2b_lsl", av, 64'hC0);
        chk("b2b_lsr", bv, 64'h3);

        op_valid = 1'b1; b_addr = 5'd2; b_sel = 1'b1; k = 64'h0; dst_sel = 2'b01;
        reg_addr = 5'd14; reg_w = 1'b1;
        step();
        clr();
        read_regs(5'd14, 5'd0, av, bv);
        chk("dst_bport", av, 64'd12);

        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("idle_ack_req", 64'(mem_req), 64'h0);
        chk("idle_ack_pc", 64'(rom_addr), 64'h54);

        clr();
        op_valid = 1'b1; mem_op = 2'b10; fs = 3'b001; b_sel = 1'b1; k = 64'h1; a_addr = 5'd2;
        step();
        op_valid = 1'b0; fs = 3'b111; b_sel = 1'b1; k = 64'h1;
        chk("rst_pre_req", 64'(mem_req), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_req", 64'(mem_req), 64'h0);
        chk("rst_async_rom", 64'(rom_addr), 64'h0);
        chk("rst_async_status", 64'(status), 64'h0);
        chk("rst_async_ready", 64'(op_ready), 64'h1);
        step();
        rst_n = 1'b1;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("late_ack_req", 64'(mem_req), 64'h0);
        chk("late_ack_rom", 64'(rom_addr), 64'h0);
        chk("late_ack_ready", 64'(op_ready), 64'h1);
        read_regs(5'd2, 5'd4, av, bv);
        chk("rst_cleared_r2", av, 64'h0);
        chk("rst_cleared_r4", bv, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/datapath_hs.md
Name: datapath_hs

Overview:
Parametrised, handshaked successor to the single-cycle CPU datapath. It holds the register file, ALU, status register and program counter. It executes one micro-op per accepted control word: non-memory ops complete in one cycle, and memory ops stall on an external req/ack data-memory interface. It sits between the control unit (op_valid/op_ready) and the instruction ROM (rom_addr) / data RAM.

Parameters:
DATA_W, 64, data/register width (power of 2, >=8)
PC_W, 32, program counter width (<= DATA_W)
NREGS, 32, register count; address width RA_W = clog2(NREGS)
ZERO_REG, NREGS-1, register index hardwired to zero (reads 0, writes dropped)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
op_valid  in  1  control word valid
op_ready  out  1  datapath can accept a control word
reg_addr  in  RA_W  write-back register
a_addr  in  RA_W  A read port
b_addr  in  RA_W  B read port
k  in  DATA_W  constant
fs  in  3  ALU function
b_sel  in  1  ALU B operand: 1=k, 0=B port
c0  in  1  ALU carry-in (ADD only)
dst_sel  in  2  write-back source: 00 ALU f, 01 B port, 10 mem_rdata, 11 pc+4
reg_w  in  1  register write enable
stat_en  in  1  status register update enable
mem_op  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
ps  in  2  PC: 00 hold, 01 +4, 10 load, 11 offset
pc_sel  in  1  PC load source: 1=k, 0=A port
mem_req  out  1  memory request
mem_we  out  1  1=store
mem_addr  out  DATA_W  registered memory address
mem_wdata  out  DATA_W  registered store data
mem_ack  in  1  memory completion, one-cycle pulse
mem_rdata  in  DATA_W  load data, valid with mem_ack
rom_addr  out  PC_W  current PC
status  out  5  {v,c,n,z stored, z live from ALU}

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers, PC, status, mem_addr and mem_wdata clear to 0;
  - mem_req=0, mem_we=0, state=IDLE, op_ready=1 once rst deasserts.
- Reset during MEM_WAIT aborts the transaction; mem_req drops immediately.
- Read ports are combinational; a_addr/b_addr==ZERO_REG reads 0.
- ALU (combinational, operands A and mux_out):
  - 000 AND, 001 OR, 010 ADD (A+B+c0), 011 SUB (A+~B+1), 100 XOR;
  - 101 LSL A by B[clog2(DATA_W)-1:0], 110 LSR likewise, 111 pass B.
- Flags:
  - z = (f==0); n = f[DATA_W-1];
  - c = carry out and v = signed overflow for ADD/SUB only, 0 for other ops.
- FSM states IDLE and MEM_WAIT. op_ready = (state==IDLE).
- IDLE, accept = op_valid & op_ready:
  - mem_op none: on the accepting edge, write back if reg_w & reg_addr!=ZERO_REG, update status if stat_en, update PC. Latency 1 cycle, back-to-back ops allowed.
  - load/store: on the accepting edge, mem_addr<=f, mem_wdata<=B port, mem_we<=(store), mem_req<=1, latch reg_addr/reg_w/dst_sel/ps/PC target and status; go to MEM_WAIT. Status (if stat_en) updates at acceptance.
- MEM_WAIT:
  - mem_req, mem_addr, mem_wdata and mem_we are held stable until mem_ack.
  - On mem_ack: load writes mem_rdata (dst_sel must be 10; other dst_sel uses latched value), the PC update is applied, mem_req<=0, return to IDLE. op_ready rises the following cycle.
  - Minimum memory op latency is 2 cycles (accept, ack).
  - mem_ack in IDLE is ignored.
- PC update:
  - +4: pc+4, wrapping mod 2^PC_W;
  - load: (pc_sel? k : A)[PC_W-1:0];
  - offset: pc + (k[PC_W-1:0]<<2), wrapping.
  - PC-relative values use the PC at acceptance.
- dst_sel 11 writes the zero-extended pc+4 of the accepted op (link).
- Simultaneous write and read of the same register in one cycle: the read returns the old value; no bypass is required.
- status[0] is the live z of the current ALU inputs; status[4:1] are registered.

Test Plan:
- Reset, then ADD with r1=5, k=7, b_sel=1, reg_w, stat_en, ps=01 -> r2=12, status[4:1]=0000, rom_addr=4 after one edge.
- SUB r1=3, k=3 with stat_en -> stored z=1, c=1; then ADD 0x7FFF..F+1 -> v=1, n=1, c=0.
- Store r3=0xDEAD to addr r0+k=0x10, ack after 3 wait cycles -> mem_req held 3 cycles, mem_addr=0x10, mem_wdata=0xDEAD, op_ready=0 until the cycle after ack; load from 0x10 with rdata=0xDEAD -> r4=0xDEAD.
- Write 0x55 to ZERO_REG, then read it -> A=0; ps=11 with k=-2 from pc=0x20 -> rom_addr=0x18; ps=10 with pc_sel=1, k=0x100 -> 0x100.
- Assert rst low mid-MEM_WAIT -> mem_req=0, rom_addr=0, status=0 asynchronously; a late mem_ack is ignored.
- dst_sel=11 at pc=0x40 -> link register=0x44; op_valid held high for 4 ALU ops -> 4 results in 4 cycles.
